// File: rtl/cpu_core_v2_if.sv
// rtl/cpu_core_v2_if.sv - external memory bus between cpu_core_v2 and its memory
// Signals:
//   data_i        8  read data returned by memory
//   data_valid_i  1  read data valid at the tick edge (low = wait state)
//   data_o        8  write data
//   address_o    16  bus address
//   bus_read_o    1  read strobe
//   bus_write_o   1  write strobe
// Modports: master = CPU side, slave = memory side.
interface cpu_core_v2_if;
    logic [7:0]  data_i;
    logic        data_valid_i;
    logic [7:0]  data_o;
    logic [15:0] address_o;
    logic        bus_read_o;
    logic        bus_write_o;

    modport master (
        input  data_i, data_valid_i,
        output data_o, address_o, bus_read_o, bus_write_o
    );

    modport slave (
        output data_i, data_valid_i,
        input  data_o, address_o, bus_read_o, bus_write_o
    );
endinterface

// File: rtl/cpu_core_v2.sv
// rtl/cpu_core_v2.sv - tick-driven 6502-subset CPU core with registered memory bus
// Ports:
//   clock_i            system clock
//   reset_ni           asynchronous active-low reset
//   bus                cpu_core_v2_if.master memory bus (registered outputs)
//   tick_o             one-clock CPU tick enable, every CLOCK_DIVIDER clocks
//   program_counter_o  PC
//   accumulator_o      A
//   index_x_o          X
//   status_o           P (N V - B D I Z C)
//   stack_pointer_o    SP
module cpu_core_v2 #(
    parameter int unsigned CLOCK_DIVIDER = 12,
    parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
    parameter logic [7:0]  STACK_PAGE    = 8'h01,
    parameter logic [7:0]  INITIAL_SP    = 8'hFD
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    cpu_core_v2_if.master       bus,
    output logic                tick_o,
    output logic [15:0]         program_counter_o,
    output logic [7:0]          accumulator_o,
    output logic [7:0]          index_x_o,
    output logic [7:0]          status_o,
    output logic [7:0]          stack_pointer_o
);
    typedef enum logic [2:0] {RESET_LO, RESET_HI, FETCH, OP1, OP2, OP3} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIVIDER - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic        tick_q;
    logic [15:0] address_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [7:0]  data_out_q;
    logic [15:0] pc_q;
    logic [7:0]  a_q, x_q, sp_q, p_q;
    logic [7:0]  opcode_q;
    logic [7:0]  lo_q;

    logic [7:0]  rd;
    logic        stall;
    logic [15:0] pc_inc;
    logic [8:0]  adc_sum;
    logic        adc_v;

    assign rd      = bus.data_i;
    // A read without valid data freezes the whole machine for this tick.
    assign stall   = bus_read_q && !bus.data_valid_i;
    assign pc_inc  = pc_q + 16'd1;
    assign adc_sum = {1'b0, a_q} + {1'b0, rd} + {8'h00, p_q[0]};
    assign adc_v   = (a_q[7] == rd[7]) && (adc_sum[7] != a_q[7]);

    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] r);
        return {r[7], p[6:2], (r == 8'h00), p[0]};
    endfunction

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q  <= 8'h00;
            tick_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= 8'h00;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + 8'd1;
            tick_q <= 1'b0;
        end
    end

    // Each tick completes the bus cycle currently presented and sets up the next one.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= RESET_LO;
            address_q   <= RESET_VECTOR;
            bus_read_q  <= 1'b1;
            bus_write_q <= 1'b0;
            data_out_q  <= 8'h00;
            pc_q        <= 16'h0000;
            a_q         <= 8'h00;
            x_q         <= 8'h00;
            sp_q        <= INITIAL_SP;
            p_q         <= 8'h34;
            opcode_q    <= 8'h00;
            lo_q        <= 8'h00;
        end else if (tick_q && !stall) begin
            case (state_q)
                RESET_LO: begin
                    lo_q      <= rd;
                    address_q <= RESET_VECTOR + 16'd1;
                    state_q   <= RESET_HI;
                end
                RESET_HI: begin
                    pc_q      <= {rd, lo_q};
                    address_q <= {rd, lo_q};
                    state_q   <= FETCH;
                end
                FETCH: begin
                    opcode_q  <= rd;
                    pc_q      <= pc_inc;
                    address_q <= pc_inc;
                    state_q   <= OP1;
                end
                OP1: begin
                    state_q <= FETCH;
                    case (opcode_q)
                        8'hA9: begin
                            a_q <= rd; p_q <= set_nz(p_q, rd);
                            pc_q <= pc_inc; address_q <= pc_inc;
                        end
                        8'h69: begin
                            a_q <= adc_sum[7:0];
                            p_q <= {adc_sum[7], adc_v, p_q[5:2], (adc_sum[7:0] == 8'h00), adc_sum[8]};
                            pc_q <= pc_inc; address_q <= pc_inc;
                        end
                        8'hA5, 8'h85: begin
                            pc_q      <= pc_inc;
                            address_q <= {8'h00, rd};
                            state_q   <= OP2;
                            if (opcode_q == 8'h85) begin
                                bus_read_q <= 1'b0; bus_write_q <= 1'b1; data_out_q <= a_q;
                            end
                        end
                        8'hAD, 8'h8D, 8'h4C: begin
                            lo_q <= rd; pc_q <= pc_inc; address_q <= pc_inc; state_q <= OP2;
                        end
                        8'hE8: begin
                            x_q <= x_q + 8'd1; p_q <= set_nz(p_q, x_q + 8'd1); address_q <= pc_q;
                        end
                        8'hCA: begin
                            x_q <= x_q - 8'd1; p_q <= set_nz(p_q, x_q - 8'd1); address_q <= pc_q;
                        end
                        8'h48: begin
                            address_q  <= {STACK_PAGE, sp_q};
                            bus_read_q <= 1'b0; bus_write_q <= 1'b1; data_out_q <= a_q;
                            state_q    <= OP2;
                        end
                        8'h68: begin
                            // Dummy stack read before the real pull, as on the 6502.
                            address_q <= {STACK_PAGE, sp_q};
                            state_q   <= OP2;
                        end
                        default: address_q <= pc_q;
                    endcase
                end
                OP2: begin
                    state_q <= FETCH;
                    case (opcode_q)
                        8'hA5: begin
                            a_q <= rd; p_q <= set_nz(p_q, rd); address_q <= pc_q;
                        end
                        8'h85, 8'h48: begin
                            bus_read_q <= 1'b1; bus_write_q <= 1'b0; address_q <= pc_q;
                            if (opcode_q == 8'h48) sp_q <= sp_q - 8'd1;
                        end
                        8'hAD, 8'h8D: begin
                            pc_q      <= pc_inc;
                            address_q <= {rd, lo_q};
                            state_q   <= OP3;
                            if (opcode_q == 8'h8D) begin
                                bus_read_q <= 1'b0; bus_write_q <= 1'b1; data_out_q <= a_q;
                            end
                        end
                        8'h4C: begin
                            pc_q <= {rd, lo_q}; address_q <= {rd, lo_q};
                        end
                        8'h68: begin
                            address_q <= {STACK_PAGE, sp_q + 8'd1};
                            state_q   <= OP3;
                        end
                        default: address_q <= pc_q;
                    endcase
                end
                OP3: begin
                    state_q     <= FETCH;
                    address_q   <= pc_q;
                    bus_read_q  <= 1'b1;
                    bus_write_q <= 1'b0;
                    if (opcode_q == 8'hAD) begin
                        a_q <= rd; p_q <= set_nz(p_q, rd);
                    end else if (opcode_q == 8'h68) begin
                        a_q <= rd; p_q <= set_nz(p_q, rd); sp_q <= sp_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= FETCH;
                    address_q <= pc_q;
                end
            endcase
        end
    end

    assign bus.address_o     = address_q;
    assign bus.bus_read_o    = bus_read_q;
    assign bus.bus_write_o   = bus_write_q;
    assign bus.data_o        = data_out_q;
    assign tick_o            = tick_q;
    assign program_counter_o = pc_q;
    assign accumulator_o     = a_q;
    assign index_x_o         = x_q;
    assign status_o          = p_q;
    assign stack_pointer_o   = sp_q;
endmodule

// File: tb/tb_cpu_core_v2.sv
// tb/tb_cpu_core_v2.sv - directed-vector bench for cpu_core_v2 with a byte memory model
module tb_cpu_core_v2;
    localparam int DIV = 4;

    logic        clk;
    logic        reset_ni;
    logic        tick_o;
    logic [15:0] pc_o;
    logic [7:0]  a_o, x_o, p_o, sp_o;

    cpu_core_v2_if bus_if ();

    cpu_core_v2 #(.CLOCK_DIVIDER(DIV)) dut (
        .clock_i           (clk),
        .reset_ni          (reset_ni),
        .bus               (bus_if.master),
        .tick_o            (tick_o),
        .program_counter_o (pc_o),
        .accumulator_o     (a_o),
        .index_x_o         (x_o),
        .status_o          (p_o),
        .stack_pointer_o   (sp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          stall_left = 0;
    logic [15:0] stall_addr = 16'h1234;
    logic [15:0] last_wr_addr = 16'h0000;
    logic [7:0]  last_wr_data = 8'h00;
    logic [15:0] last_rd_addr = 16'h0000;
    logic        rw_clash = 1'b0;

    typedef struct {
        int          ticks;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [7:0]  a, x, p, sp;
    } vec_t;
    vec_t tbl [20];
    logic [7:0] prog [28];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!tick_o && guard < 4 * DIV);
            if (!tick_o) check("tick_wait", {31'b0, tick_o}, 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: data/valid driven at negedge, consumed by the DUT at the next tick edge.
    initial begin
        bus_if.data_i       = 8'h00;
        bus_if.data_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            bus_if.data_i       = mem[bus_if.address_o];
            bus_if.data_valid_i = 1'b1;
            if (bus_if.bus_read_o && bus_if.bus_write_o) rw_clash = 1'b1;
            if (tick_o) begin
                if (bus_if.bus_write_o) begin
                    mem[bus_if.address_o] = bus_if.data_o;
                    wr_cnt++;
                    last_wr_addr = bus_if.address_o;
                    last_wr_data = bus_if.data_o;
                end else if (bus_if.bus_read_o) begin
                    if (stall_left > 0 && bus_if.address_o == stall_addr) begin
                        bus_if.data_valid_i = 1'b0;
                        stall_left--;
                    end else begin
                        last_rd_addr = bus_if.address_o;
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string pfx);
        check({pfx, "_addr"},  bus_if.address_o, 16'hFFFC);
        check({pfx, "_rd"},    bus_if.bus_read_o, 1);
        check({pfx, "_wr"},    bus_if.bus_write_o, 0);
        check({pfx, "_dout"},  bus_if.data_o, 8'h00);
        check({pfx, "_tick"},  tick_o, 0);
        check({pfx, "_a"},     a_o, 8'h00);
        check({pfx, "_x"},     x_o, 8'h00);
        check({pfx, "_pc"},    pc_o, 16'h0000);
        check({pfx, "_sp"},    sp_o, 8'hFD);
        check({pfx, "_p"},     p_o, 8'h34);
    endtask

    initial begin
        int first_tick;
        reset_ni = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        prog = '{8'hEA, 8'hA9, 8'h7F, 8'h69, 8'h01, 8'hA9, 8'hFF, 8'h69, 8'h01,
                 8'hAD, 8'h34, 8'h12, 8'hA9, 8'h5A, 8'h48, 8'hA9, 8'h00, 8'h68,
                 8'hCA, 8'hE8, 8'hCA, 8'h85, 8'h40, 8'hA5, 8'h40, 8'h4C, 8'h00, 8'h90};
        for (int i = 0; i < 28; i++) mem[16'h8000 + i] = prog[i];
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[16'h1234] = 8'h80;
        mem[16'h9000] = 8'h02;
        for (int i = 16'h9001; i <= 16'h90FE; i++) mem[i] = 8'h48;
        mem[16'h90FF] = 8'h8D;
        mem[16'h9100] = 8'h00;
        mem[16'h9101] = 8'h30;

        //            ticks addr      pc        a      x      p      sp
        tbl[0]  = '{1, 16'hFFFD, 16'h0000, 8'h00, 8'h00, 8'h34, 8'hFD};
        tbl[1]  = '{1, 16'h8000, 16'h8000, 8'h00, 8'h00, 8'h34, 8'hFD};
        tbl[2]  = '{2, 16'h8001, 16'h8001, 8'h00, 8'h00, 8'h34, 8'hFD};
        tbl[3]  = '{2, 16'h8003, 16'h8003, 8'h7F, 8'h00, 8'h34, 8'hFD};
        tbl[4]  = '{2, 16'h8005, 16'h8005, 8'h80, 8'h00, 8'hF4, 8'hFD};
        tbl[5]  = '{2, 16'h8007, 16'h8007, 8'hFF, 8'h00, 8'hF4, 8'hFD};
        tbl[6]  = '{2, 16'h8009, 16'h8009, 8'h00, 8'h00, 8'h37, 8'hFD};
        tbl[7]  = '{6, 16'h1234, 16'h800C, 8'h00, 8'h00, 8'h37, 8'hFD};
        tbl[8]  = '{1, 16'h800C, 16'h800C, 8'h80, 8'h00, 8'hB5, 8'hFD};
        tbl[9]  = '{2, 16'h800E, 16'h800E, 8'h5A, 8'h00, 8'h35, 8'hFD};
        tbl[10] = '{3, 16'h800F, 16'h800F, 8'h5A, 8'h00, 8'h35, 8'hFC};
        tbl[11] = '{2, 16'h8011, 16'h8011, 8'h00, 8'h00, 8'h37, 8'hFC};
        tbl[12] = '{4, 16'h8012, 16'h8012, 8'h5A, 8'h00, 8'h35, 8'hFD};
        tbl[13] = '{2, 16'h8013, 16'h8013, 8'h5A, 8'hFF, 8'hB5, 8'hFD};
        tbl[14] = '{2, 16'h8014, 16'h8014, 8'h5A, 8'h00, 8'h37, 8'hFD};
        tbl[15] = '{2, 16'h8015, 16'h8015, 8'h5A, 8'hFF, 8'hB5, 8'hFD};
        tbl[16] = '{3, 16'h8017, 16'h8017, 8'h5A, 8'hFF, 8'hB5, 8'hFD};
        tbl[17] = '{3, 16'h8019, 16'h8019, 8'h5A, 8'hFF, 8'h35, 8'hFD};
        tbl[18] = '{3, 16'h9000, 16'h9000, 8'h5A, 8'hFF, 8'h35, 8'hFD};
        tbl[19] = '{2, 16'h9001, 16'h9001, 8'h5A, 8'hFF, 8'h35, 8'hFD};

        repeat (3) @(negedge clk);
        check_reset_state("rst");
        stall_left = 3;

        reset_ni   = 1'b1;
        first_tick = 0;
        for (int k = 1; k <= DIV + 2; k++) begin
            @(posedge clk);
            #1;
            if (tick_o) begin
                first_tick = k;
                break;
            end
        end
        check("first_tick", first_tick, DIV);

        for (int i = 0; i < 20; i++) begin
            advance(tbl[i].ticks);
            check($sformatf("v%0d_addr", i), bus_if.address_o, tbl[i].addr);
            check($sformatf("v%0d_rd", i),   bus_if.bus_read_o, 1);
            check($sformatf("v%0d_pc", i),   pc_o, tbl[i].pc);
            check($sformatf("v%0d_a", i),    a_o, tbl[i].a);
            check($sformatf("v%0d_x", i),    x_o, tbl[i].x);
            check($sformatf("v%0d_p", i),    p_o, tbl[i].p);
            check($sformatf("v%0d_sp", i),   sp_o, tbl[i].sp);
            if (i == 1)  check("vec_rd_fffd", last_rd_addr, 16'hFFFD);
            if (i == 8)  check("stall_used", stall_left, 0);
            if (i == 10) begin
                check("pha_wr_cnt", wr_cnt, 1);
                check("pha_wr_addr", last_wr_addr, 16'h01FD);
                check("pha_wr_data", last_wr_data, 8'h5A);
            end
            if (i == 12) check("pla_rd_addr", last_rd_addr, 16'h01FD);
            if (i == 16) begin
                check("sta_zp_cnt", wr_cnt, 2);
                check("sta_zp_mem", mem[16'h0040], 8'h5A);
            end
        end

        for (int i = 0; i < 253; i++) advance(3);
        check("sp_at_00", sp_o, 8'h00);
        check("sp_00_addr", bus_if.address_o, 16'h90FE);
        advance(3);
        check("wrap_wr_addr", last_wr_addr, 16'h0100);
        check("wrap_sp", sp_o, 8'hFF);
        check("wrap_wr_cnt", wr_cnt, 256);

        advance(3);
        check("sta_abs_wr", bus_if.bus_write_o, 1);
        check("sta_abs_rd", bus_if.bus_read_o, 0);
        check("sta_abs_addr", bus_if.address_o, 16'h3000);
        check("sta_abs_data", bus_if.data_o, 8'h5A);
        for (int g = 0; g < 4 * DIV; g++) begin
            @(posedge clk);
            #1;
            if (tick_o) break;
        end
        check("write_tick_seen", tick_o, 1);
        reset_ni = 1'b0;
        #1;
        check_reset_state("midwr");
        repeat (2) @(negedge clk);
        check("midwr_no_write", wr_cnt, 256);
        check("midwr_mem", mem[16'h3000], 8'h00);

        reset_ni = 1'b1;
        advance(1);
        check("rst2_addr1", bus_if.address_o, 16'hFFFD);
        check("rst2_rd1", last_rd_addr, 16'hFFFC);
        advance(1);
        check("rst2_addr2", bus_if.address_o, 16'h8000);
        check("rst2_pc", pc_o, 16'h8000);
        check("rw_exclusive", rw_clash, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_core_v2.md
CPU_CORE_V2 -- requirements
Module: cpu_core_v2

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be: CLOCK_DIVIDER, default 12, system clocks per CPU tick (2..255); RESET_VECTOR, default 16'hFFFC, address of the reset-vector low byte; STACK_PAGE, default 8'h01, stack high address byte; INITIAL_SP, default 8'hFD, stack pointer after reset.
REQ-003 Ports SHALL be:
- clock_i  in  1  system clock
- reset_ni  in  1  async active-low reset
- data_i  in  8  read data
- data_valid_i  in  1  read data valid at tick
- data_o  out  8  write data
- address_o  out  16  bus address
- bus_read_o  out  1  read strobe
- bus_write_o  out  1  write strobe
- tick_o  out  1  CPU tick enable
- program_counter_o  out  16  PC
- accumulator_o  out  8  A
- index_x_o  out  8  X
- status_o  out  8  P
- stack_pointer_o  out  8  SP

Function
REQ-004 tick_o SHALL pulse high for one clock every CLOCK_DIVIDER clocks; the first pulse comes CLOCK_DIVIDER clocks after reset release. All architectural and bus-output state SHALL update only on tick clocks.
REQ-005 Bus outputs SHALL be registered. A read is issued when bus_read_o=1; data_i is consumed on the next tick only if data_valid_i=1. Otherwise all state holds (wait state) and the outputs stay unchanged.
REQ-006 A write SHALL hold bus_write_o=1 with stable address_o and data_o for exactly one tick. It is never stalled by data_valid_i. bus_read_o and bus_write_o SHALL never both be 1.
REQ-007 Reset sequence: fetch the PC low byte from RESET_VECTOR, then the high byte from RESET_VECTOR+1, then fetch the opcode at the new PC. Each step waits on valid.
REQ-008 Opcodes and tick counts (valid always high):
- NOP EA: 2
- LDA# A9: 2
- LDA zp A5: 3
- LDA abs AD: 4
- STA zp 85: 3
- STA abs 8D: 4
- ADC# 69: 2
- INX E8: 2
- DEX CA: 2
- PHA 48: 3
- PLA 68: 4
- JMP abs 4C: 3
REQ-009 Any other opcode SHALL execute as a 1-byte, 2-tick NOP.
REQ-010 The opcode fetch of the next instruction SHALL overlap the last tick of the current one, as in the 6502.
REQ-011 The state machine SHALL use states RESET_LO, RESET_HI, FETCH, and OP1 to OP3. An instruction returns to FETCH after its last operand or data cycle.
REQ-012 LDA, PLA, INX, and DEX SHALL set N=result[7] and Z=(result==0); other flags are unchanged.
REQ-013 ADC SHALL compute {C,A}=A+M+C with V=(A[7]==M[7])&&(R[7]!=A[7]), and SHALL set N and Z. The D flag is ignored.
REQ-014 INX and DEX SHALL wrap modulo 256: FF+1=00 with Z=1; 00-1=FF with N=1.
REQ-015 PHA SHALL write A to {STACK_PAGE,SP}, then SP-1. PLA SHALL read from {STACK_PAGE,SP+1}, with SP+1 committed. SP SHALL wrap 00<->FF with no error.
REQ-016 STA and PHA flags SHALL be unchanged.
REQ-017 PC increments SHALL wrap FFFF->0000.
REQ-018 JMP SHALL load PC from the two operand bytes, low byte first.
REQ-019 The zero-page address high byte SHALL be 00.
REQ-020 The absolute-address low byte SHALL be held internally until the high byte arrives.

Reset
REQ-021 While reset_ni=0, asynchronously, the block SHALL force: divider=0, tick_o=0, state=RESET_LO, address_o=RESET_VECTOR, bus_read_o=1, bus_write_o=0, data_o=0, A=0, X=0, PC=0000, SP=INITIAL_SP, P=8'h34.
REQ-022 Reset asserted mid-instruction, including during a write tick, SHALL abort the instruction immediately. No partial register update survives and bus_write_o drops at once.

Verification
REQ-023 Vector fetch: reset, memory FFFC=00, FFFD=80, 8000=EA -> reads at FFFC, FFFD, 8000; then PC=8001; NOP fetches next at 8001.
REQ-024 Wait states: LDA abs (AD 34 12), mem 1234=80, data_valid_i low for 3 ticks on the operand read -> completion delayed by exactly 3 ticks; A=80, N=1, Z=0.
REQ-025 ADC flags:
- A=7F, C=0, ADC #01 -> A=80, V=1, N=1, C=0.
- A=FF, C=0, ADC #01 -> A=00, C=1, Z=1, V=0.
REQ-026 Stack: SP=FD, A=5A, PHA -> one-tick write 5A at 01FD, SP=FC. Then LDA #00; PLA -> read 01FD, A=5A, SP=FD, Z=0.
REQ-027 Wrap: X=FF, INX -> X=00, Z=1. DEX -> X=FF, N=1. With SP=00, PHA writes 0100 and leaves SP=FF.
REQ-028 Mid-write reset: reset_ni asserted during the STA abs write tick -> bus_write_o=0 in the same clock; after release, the reset sequence restarts at RESET_VECTOR.
